// File: rtl/qupls_preg_free_list_pkg.sv
// Shared types and constants for the physical-register free list.
//   PREGS / NRES   : physical register count and number mapped at reset
//   pregno_t       : physical register number
//   free_slot_t    : one prefetch slot (valid + register)
//   fl_state_t     : allocator FSM states
//   popcnt()       : exact population count of a free vector
package qupls_preg_free_list_pkg;

  localparam int PREGS = 256;
  localparam int NRES  = 64;
  localparam int RBIT  = $clog2(PREGS);
  localparam int NSLOT = 4;

  typedef logic [RBIT-1:0] pregno_t;

  typedef struct packed {
    logic    v;
    pregno_t rg;
  } free_slot_t;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } fl_state_t;

  // Registers NRES and up start out free; the low ones are identity-mapped.
  localparam logic [PREGS-1:0] AVAIL_RST  = {{(PREGS-NRES){1'b1}}, {NRES{1'b0}}};
  localparam logic [PREGS-1:0] PREG0_MASK = {{(PREGS-1){1'b0}}, 1'b1};

  function automatic logic [RBIT:0] popcnt(input logic [PREGS-1:0] vec);
    logic [RBIT:0] n;
    n = '0;
    for (int i = 0; i < PREGS; i++)
      n = n + (RBIT+1)'(vec[i]);
    return n;
  endfunction

endpackage

// File: rtl/qupls_preg_free_list_if.sv
// Rename-side / commit-side bundle of the physical-register free list.
//   alloc, alloc_preg, alloc_v, stall    : allocation handshake (4 slots)
//   free_v, free_preg                    : commit frees, ports a..d
//   restore, restore_list                : branch-miss bulk free
//   avail_o, free_cnt, err               : status / checkpoint export
// master = requester (rename/commit), slave = free list.
interface qupls_preg_free_list_if;
  import qupls_preg_free_list_pkg::*;

  logic [3:0]       alloc;
  pregno_t [3:0]    alloc_preg;
  logic [3:0]       alloc_v;
  logic             stall;
  logic [3:0]       free_v;
  pregno_t [3:0]    free_preg;
  logic             restore;
  logic [PREGS-1:0] restore_list;
  logic [PREGS-1:0] avail_o;
  logic [RBIT:0]    free_cnt;
  logic             err;

  modport master (
    output alloc, free_v, free_preg, restore, restore_list,
    input  alloc_preg, alloc_v, stall, avail_o, free_cnt, err
  );

  modport slave (
    input  alloc, free_v, free_preg, restore, restore_list,
    output alloc_preg, alloc_v, stall, avail_o, free_cnt, err
  );

endinterface

// File: rtl/qupls_preg_free_list_ffo_residue.sv
// Find-first-one within one residue class of the free vector.
//   cls   : free bits of registers RES, RES+4, RES+8, ... (bit j = register 4*j+RES)
//   idx   : lowest free register of the class
//   found : class has at least one free register
module qupls_preg_free_list_ffo_residue
  import qupls_preg_free_list_pkg::*;
#(
  parameter int RES = 0
) (
  input  logic [PREGS/4-1:0] cls,
  output pregno_t            idx,
  output logic               found
);

  // Scan high to low so the last hit is the lowest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int j = PREGS/4-1; j >= 0; j--) begin
      if (cls[j]) begin
        idx   = pregno_t'(4*j + RES);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/qupls_preg_free_list.sv
// Physical-register allocator feeding the register alias table.
// Four prefetch slots offer free registers to rename with zero latency; slot k
// only holds registers with index%4 == k. Registers return on commit frees and
// on branch-miss restore. avail_o exports the live free vector for checkpoints.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : qupls_preg_free_list_if.slave (alloc/free/restore/status)
// Build option: QUPLS_FREE_CHECK_EN enables the sticky double-free flag (err).
//
// state   | meaning
// --------+---------------------------------------------------
// ST_INIT | first cycle after reset: slots fill, stall forced
// ST_RUN  | normal allocate / free / restore operation
module qupls_preg_free_list
  import qupls_preg_free_list_pkg::*;
(
  input logic                   clk,
  input logic                   rst,
  qupls_preg_free_list_if.slave bus
);

  fl_state_t        state, state_nxt;
  free_slot_t       slot     [NSLOT];
  free_slot_t       slot_nxt [NSLOT];
  logic [PREGS-1:0] avail, avail_nxt;
  logic [PREGS-1:0] held, held_nxt;
  logic [PREGS-1:0] avail_o_q;
  logic [RBIT:0]    free_cnt_q;
  logic [3:0]       slot_v, consume;
  logic             stall;
  pregno_t [3:0]    offer;

  logic [PREGS/4-1:0] cls [NSLOT];
  pregno_t            ffo_idx [NSLOT];
  logic [NSLOT-1:0]   ffo_found;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  // Split the free vector into residue classes; register 0 is never handed out.
  always_comb begin
    for (int k = 0; k < NSLOT; k++)
      for (int j = 0; j < PREGS/4; j++)
        cls[k][j] = avail[4*j + k];
    cls[0][0] = 1'b0;
  end

  for (genvar k = 0; k < NSLOT; k++) begin : g_ffo
    qupls_preg_free_list_ffo_residue #(.RES(k)) u_ffo (
      .cls   (cls[k]),
      .idx   (ffo_idx[k]),
      .found (ffo_found[k])
    );
  end

  always_comb begin
    held  = '0;
    offer = '0;
    for (int k = 0; k < NSLOT; k++) begin
      slot_v[k] = slot[k].v;
      offer[k]  = slot[k].rg;
      if (slot[k].v)
        held[slot[k].rg] = 1'b1;
    end
    // All-or-nothing: any request on an empty slot refuses the whole group.
    stall   = (state == ST_INIT) | |(bus.alloc & ~slot_v);
    consume = stall ? 4'h0 : bus.alloc;
  end

  // Refill reads the registered free vector, so a bit freed this cycle is only
  // reusable next cycle. Frees are applied last so a collision leaves the bit set.
  always_comb begin
    avail_nxt = avail;
    held_nxt  = '0;
    for (int k = 0; k < NSLOT; k++) begin
      slot_nxt[k] = slot[k];
      if (consume[k])
        slot_nxt[k].v = 1'b0;
      if ((!slot[k].v || consume[k]) && ffo_found[k]) begin
        slot_nxt[k].v  = 1'b1;
        slot_nxt[k].rg = ffo_idx[k];
        avail_nxt[ffo_idx[k]] = 1'b0;
      end
    end
    if (bus.restore)
      avail_nxt = avail_nxt | (bus.restore_list & ~held & ~PREG0_MASK);
    for (int k = 0; k < NSLOT; k++)
      if (bus.free_v[k] && bus.free_preg[k] != '0)
        avail_nxt[bus.free_preg[k]] = 1'b1;
    for (int k = 0; k < NSLOT; k++)
      if (slot_nxt[k].v)
        held_nxt[slot_nxt[k].rg] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_INIT;
      avail      <= AVAIL_RST;
      avail_o_q  <= AVAIL_RST;
      free_cnt_q <= (RBIT+1)'(PREGS - NRES);
      for (int k = 0; k < NSLOT; k++)
        slot[k] <= '0;
    end else begin
      state      <= state_nxt;
      avail      <= avail_nxt;
      avail_o_q  <= avail_nxt | held_nxt;
      free_cnt_q <= popcnt(avail_nxt);
      for (int k = 0; k < NSLOT; k++)
        slot[k] <= slot_nxt[k];
    end
  end

  assign bus.alloc_preg = offer;
  assign bus.alloc_v    = slot_v;
  assign bus.stall      = stall;
  assign bus.avail_o    = avail_o_q;
  assign bus.free_cnt   = free_cnt_q;

`ifdef QUPLS_FREE_CHECK_EN
  logic dbl_free;
  logic err_q;

  always_comb begin
    dbl_free = 1'b0;
    for (int k = 0; k < NSLOT; k++)
      if (bus.free_v[k] && bus.free_preg[k] != '0 &&
          (avail[bus.free_preg[k]] || held[bus.free_preg[k]]))
        dbl_free = 1'b1;
    if (bus.restore && |(bus.restore_list & ~PREG0_MASK & (avail | held)))
      dbl_free = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (dbl_free) begin
      err_q <= 1'b1;
`ifndef SYNTHESIS
      $display("qupls_preg_free_list: double free of a physical register");
`endif
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_qupls_preg_free_list.sv
// Directed bench for qupls_preg_free_list: vector table for steady-state
// allocate/free traffic, hand-written sequences for reset, drain, restore,
// free-of-zero, double free and mid-stream reset.
module tb_qupls_preg_free_list;
  import qupls_preg_free_list_pkg::*;

`ifdef QUPLS_FREE_CHECK_EN
  localparam int ERR_EXP = 1;
`else
  localparam int ERR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qupls_preg_free_list_if bus ();

  qupls_preg_free_list dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]    alloc;
    logic [3:0]    free_v;
    pregno_t       free_p;
    logic          exp_stall;
    logic [3:0]    exp_v;
    logic [31:0]   exp_p;
    logic [RBIT:0] exp_cnt;
  } vec_t;

  vec_t             tv [9];
  logic [PREGS-1:0] rst_av;
  logic [PREGS-1:0] rl;
  logic [PREGS-1:0] top3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chkw(input string name, input logic [PREGS-1:0] act, input logic [PREGS-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    bus.alloc        = '0;
    bus.free_v       = '0;
    bus.free_preg    = '0;
    bus.restore      = 1'b0;
    bus.restore_list = '0;
  endtask

  initial begin
    //        alloc  free_v free_p stall  alloc_v  offers {s3,s2,s1,s0}              cnt after
    tv[0] = '{4'hF, 4'h0, 8'd0,  1'b0, 4'hF, {8'd67, 8'd66, 8'd65, 8'd64}, 9'd184};
    tv[1] = '{4'hF, 4'h0, 8'd0,  1'b0, 4'hF, {8'd71, 8'd70, 8'd69, 8'd68}, 9'd180};
    tv[2] = '{4'hF, 4'h0, 8'd0,  1'b0, 4'hF, {8'd75, 8'd74, 8'd73, 8'd72}, 9'd176};
    tv[3] = '{4'h5, 4'h0, 8'd0,  1'b0, 4'hF, {8'd79, 8'd78, 8'd77, 8'd76}, 9'd174};
    tv[4] = '{4'h0, 4'h2, 8'd65, 1'b0, 4'hF, {8'd79, 8'd82, 8'd77, 8'd80}, 9'd175};
    tv[5] = '{4'h2, 4'h0, 8'd0,  1'b0, 4'hF, {8'd79, 8'd82, 8'd77, 8'd80}, 9'd174};
    tv[6] = '{4'h0, 4'h0, 8'd0,  1'b0, 4'hF, {8'd79, 8'd82, 8'd65, 8'd80}, 9'd174};
    tv[7] = '{4'h8, 4'h1, 8'd0,  1'b0, 4'hF, {8'd79, 8'd82, 8'd65, 8'd80}, 9'd173};
    tv[8] = '{4'h0, 4'h0, 8'd0,  1'b0, 4'hF, {8'd83, 8'd82, 8'd65, 8'd80}, 9'd173};

    rst_av = '0;
    for (int i = NRES; i < PREGS; i++) rst_av[i] = 1'b1;
    top3 = '0;
    top3[255] = 1'b1; top3[254] = 1'b1; top3[253] = 1'b1;

    // Reset state
    rst = 1'b1;
    idle_in();
    repeat (2) tick();
    chk("rst alloc_v", 32'(bus.alloc_v), 0);
    chk("rst stall", 32'(bus.stall), 1);
    chk("rst free_cnt", 32'(bus.free_cnt), 192);
    chkw("rst avail_o", bus.avail_o, rst_av);
    chk("rst err", 32'(bus.err), 0);

    rst = 1'b0;
    #1;
    chk("init stall", 32'(bus.stall), 1);
    tick();
    tick();
    chk("post-init alloc_v", 32'(bus.alloc_v), 15);
    chk("post-init slots", 32'(bus.alloc_preg), {8'd67, 8'd66, 8'd65, 8'd64});
    chk("post-init free_cnt", 32'(bus.free_cnt), 188);
    chk("post-init stall", 32'(bus.stall), 0);
    chkw("post-init avail_o", bus.avail_o, rst_av);

    // Vector table
    for (int i = 0; i < 9; i++) begin
      bus.alloc     = tv[i].alloc;
      bus.free_v    = tv[i].free_v;
      bus.free_preg = {4{tv[i].free_p}};
      #1;
      chk($sformatf("tv%0d stall", i), 32'(bus.stall), 32'(tv[i].exp_stall));
      chk($sformatf("tv%0d alloc_v", i), 32'(bus.alloc_v), 32'(tv[i].exp_v));
      chk($sformatf("tv%0d offers", i), 32'(bus.alloc_preg), tv[i].exp_p);
      tick();
      idle_in();
      chk($sformatf("tv%0d free_cnt", i), 32'(bus.free_cnt), 32'(tv[i].exp_cnt));
      chk($sformatf("tv%0d avail0", i), 32'(bus.avail_o[0]), 0);
    end

    // Mid-stream reset with full slots and an in-flight free
    rst           = 1'b1;
    bus.alloc     = 4'hF;
    bus.free_v    = 4'h1;
    bus.free_preg = {4{8'd64}};
    tick();
    idle_in();
    chk("midrst alloc_v", 32'(bus.alloc_v), 0);
    chk("midrst stall", 32'(bus.stall), 1);
    chk("midrst free_cnt", 32'(bus.free_cnt), 192);
    chkw("midrst avail_o", bus.avail_o, rst_av);
    rst = 1'b0;
    tick();
    tick();
    chk("midrst slots", 32'(bus.alloc_preg), {8'd67, 8'd66, 8'd65, 8'd64});
    chk("midrst alloc_v2", 32'(bus.alloc_v), 15);
    chk("midrst free_cnt2", 32'(bus.free_cnt), 188);

    // Drain until only 252..255 remain, all in slots
    for (int j = 0; j < 47; j++) begin
      bus.alloc = 4'hF;
      #1;
      chk($sformatf("drain%0d stall", j), 32'(bus.stall), 0);
      chk($sformatf("drain%0d slot0", j), 32'(bus.alloc_preg[0]), 64 + 4*j);
      tick();
    end
    idle_in();
    chk("drained free_cnt", 32'(bus.free_cnt), 0);
    chk("drained slots", 32'(bus.alloc_preg), {8'd255, 8'd254, 8'd253, 8'd252});

    bus.alloc = 4'h1;
    tick();
    bus.alloc = 4'hF;
    #1;
    chk("short stall", 32'(bus.stall), 1);
    tick();
    idle_in();
    #1;
    chk("short alloc_v", 32'(bus.alloc_v), 14);
    chk("short slots", 32'(bus.alloc_preg[3:1]), 32'({8'd255, 8'd254, 8'd253}));
    chk("short free_cnt", 32'(bus.free_cnt), 0);
    chkw("short avail_o", bus.avail_o, top3);

    // Free 80: visible in avail next cycle, in slot 0 the cycle after
    bus.free_v    = 4'h1;
    bus.free_preg = {4{8'd80}};
    tick();
    idle_in();
    chk("free80 free_cnt", 32'(bus.free_cnt), 1);
    chk("free80 alloc_v", 32'(bus.alloc_v), 14);
    tick();
    chk("free80 alloc_v2", 32'(bus.alloc_v), 15);
    chk("free80 slot0", 32'(bus.alloc_preg[0]), 80);
    chk("free80 free_cnt2", 32'(bus.free_cnt), 0);

    // Restore 100..103 together with alloc of slots 0,1
    rl = '0;
    for (int i = 100; i < 104; i++) rl[i] = 1'b1;
    bus.alloc        = 4'h3;
    bus.restore      = 1'b1;
    bus.restore_list = rl;
    #1;
    chk("restore stall", 32'(bus.stall), 0);
    tick();
    idle_in();
    chk("restore avail_o", 32'(bus.avail_o[103:100]), 15);
    chk("restore free_cnt", 32'(bus.free_cnt), 4);
    chk("restore alloc_v", 32'(bus.alloc_v), 12);
    tick();
    chk("restore refill v", 32'(bus.alloc_v), 15);
    chk("restore refill slots", 32'(bus.alloc_preg[1:0]), 32'({8'd101, 8'd100}));
    chk("restore refill cnt", 32'(bus.free_cnt), 2);

    // Free of register 0 is ignored
    bus.free_v    = 4'h1;
    bus.free_preg = '0;
    tick();
    idle_in();
    chk("free0 avail0", 32'(bus.avail_o[0]), 0);
    chk("free0 err", 32'(bus.err), 0);
    chk("free0 free_cnt", 32'(bus.free_cnt), 2);

    // Free 70 twice
    bus.free_v    = 4'h4;
    bus.free_preg = {4{8'd70}};
    tick();
    idle_in();
    chk("free70a free_cnt", 32'(bus.free_cnt), 3);
    chk("free70a err", 32'(bus.err), 0);
    bus.free_v    = 4'h4;
    bus.free_preg = {4{8'd70}};
    tick();
    idle_in();
    chk("free70b err", 32'(bus.err), ERR_EXP);
    chk("free70b free_cnt", 32'(bus.free_cnt), 3);

    bus.alloc = 4'hF;
    #1;
    chk("post-dbl stall", 32'(bus.stall), 0);
    tick();
    idle_in();
    chk("post-dbl alloc_v", 32'(bus.alloc_v), 12);
    chk("post-dbl slots", 32'(bus.alloc_preg[3:2]), 32'({8'd103, 8'd70}));
    chk("post-dbl free_cnt", 32'(bus.free_cnt), 1);
    chk("post-dbl err", 32'(bus.err), ERR_EXP);
    tick();
    chk("held err", 32'(bus.err), ERR_EXP);

    rst = 1'b1;
    tick();
    chk("err cleared", 32'(bus.err), 0);
    rst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
